// File: rtl/mod_sub_unit.sv
// ---------------------------------------------------------------------------
// mod_sub_unit : two-stage pipelined modular subtractor, out = (a - b) mod q
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mod_sub_unit #(
    parameter int BIT_WIDTH = 54
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic [BIT_WIDTH-1:0] q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out
);

    logic                 s1_valid_q;
    logic [BIT_WIDTH-1:0] s1_diff_q;
    logic                 s1_borrow_q;
    logic [BIT_WIDTH-1:0] s1_mod_q;

    logic [BIT_WIDTH:0]   diff_d;
    logic [BIT_WIDTH-1:0] result_d;
    logic                 s2_accept;
    logic                 s1_advance;
    logic                 in_fire;

    // Extra MSB of the widened difference is the borrow out of a - b.
    assign diff_d     = {1'b0, a} - {1'b0, b};
    assign result_d   = s1_borrow_q ? (s1_diff_q + s1_mod_q) : s1_diff_q;

    assign s2_accept  = !out_valid || out_ready;
    assign s1_advance = s1_valid_q && s2_accept;
    assign in_ready   = rstn && (!s1_valid_q || s1_advance);
    assign in_fire    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid_q  <= 1'b0;
            s1_diff_q   <= '0;
            s1_borrow_q <= 1'b0;
            s1_mod_q    <= '0;
            out_valid   <= 1'b0;
            out         <= '0;
        end else begin
            if (in_fire) begin
                s1_valid_q  <= 1'b1;
                s1_diff_q   <= diff_d[BIT_WIDTH-1:0];
                s1_borrow_q <= diff_d[BIT_WIDTH];
                s1_mod_q    <= q;
            end else if (s1_advance) begin
                s1_valid_q  <= 1'b0;
            end

            if (s2_accept) begin
                out_valid <= s1_valid_q;
                if (s1_valid_q) begin
                    out <= result_d;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mod_sub_unit.sv
// ---------------------------------------------------------------------------
// tb_mod_sub_unit : vector table plus scoreboard bench for mod_sub_unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mod_sub_unit;

    localparam int W = 54;
    localparam logic [W-1:0] QB = 54'h3FFFFFFFFED001;
    localparam logic [W-1:0] QMAX = 54'h3FFFFFFFFFFFFF;

    logic         clk       = 1'b0;
    logic         rstn      = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic [W-1:0] q         = QB;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out;

    always #5 clk = ~clk;

    mod_sub_unit #(.BIT_WIDTH(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .q         (q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] e;
    } vec_t;

    vec_t         tbl[12];
    logic [W-1:0] exp_q[$];
    int           checks    = 0;
    int           errors    = 0;
    int           stall_cnt = 0;
    int           pops      = 0;
    int           cyc       = 0;
    bit           held_v    = 0;
    bit           rdy_run   = 0;
    logic [W-1:0] held_val  = '0;
    logic [63:0]  ra, rb;
    logic [W-1:0] av, bv;
    int           p0, c0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] m);
        logic [63:0] t;
        t = (64'(x) + 64'(m) - 64'(y)) % 64'(m);
        return t[W-1:0];
    endfunction

    always @(posedge clk) cyc++;

    // Output monitor: pops the scoreboard and checks hold-while-stalled.
    always @(negedge clk) begin
        if (!rstn) begin
            held_v = 0;
        end else begin
            if (held_v) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_out", 64'(out), 64'(held_val));
            end
            held_v   = out_valid && !out_ready;
            held_val = out;
            if (in_valid && !in_ready) stall_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %h expected no output", out);
                end else begin
                    chk("result", 64'(out), 64'(exp_q.pop_front()));
                    pops++;
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic [W-1:0] xq, input logic [W-1:0] ev);
        int n;
        n = 0;
        a = xa; b = xb; q = xq; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end else begin
            exp_q.push_back(ev);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending got %0d expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation got stuck expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{QB - 54'd1, QB - 54'd1, QB, 54'd0};
        tbl[1]  = '{54'd2, QB - 54'd1, QB, 54'd3};
        tbl[2]  = '{54'd0, 54'd1, QB, 54'h3FFFFFFFFED000};
        tbl[3]  = '{QB - 54'd1, 54'd0, QB, QB - 54'd1};
        tbl[4]  = '{54'd5, 54'd10, 54'd97, 54'd92};
        tbl[5]  = '{54'd10, 54'd5, QB, 54'd5};
        tbl[6]  = '{54'd0, 54'd96, 54'd97, 54'd1};
        tbl[7]  = '{54'd96, 54'd0, 54'd97, 54'd96};
        tbl[8]  = '{54'd0, 54'd1, 54'd2, 54'd1};
        tbl[9]  = '{54'd1, 54'd1, 54'd2, 54'd0};
        tbl[10] = '{54'd0, QMAX - 54'd1, QMAX, 54'd1};
        tbl[11] = '{54'd5, 54'd3, 54'd97, 54'd2};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out", 64'(out), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rstn = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // First transaction latency.
        send(54'd0, 54'd0, QB, 54'd0);
        chk("lat1_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat2_valid", 64'(out_valid), 64'd1);
        chk("lat2_out", 64'(out), 64'd0);
        drain();

        // Directed vector table, back to back.
        for (int i = 0; i < 12; i++) send(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].e);
        drain();

        // Random, no backpressure: one transfer per cycle.
        stall_cnt = 0;
        p0 = pops;
        c0 = cyc;
        for (int i = 0; i < 4096; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            av = W'((ra & ((64'd1 << W) - 64'd1)) % 64'(QB));
            bv = W'((rb & ((64'd1 << W) - 64'd1)) % 64'(QB));
            send(av, bv, QB, model(av, bv, QB));
        end
        chk("nobp_cycles", 64'(cyc - c0), 64'd4096);
        drain();
        chk("nobp_stalls", 64'(stall_cnt), 64'd0);
        chk("nobp_count", 64'(pops - p0), 64'd4096);

        // Random, random out_ready.
        stall_cnt = 0;
        p0 = pops;
        rdy_run = 1;
        fork
            begin
                for (int i = 0; i < 4096; i++) begin
                    ra = {$urandom, $urandom};
                    rb = {$urandom, $urandom};
                    av = W'((ra & ((64'd1 << W) - 64'd1)) % 64'(QB));
                    bv = W'((rb & ((64'd1 << W) - 64'd1)) % 64'(QB));
                    send(av, bv, QB, model(av, bv, QB));
                end
                rdy_run = 0;
            end
            begin
                while (rdy_run) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();
        chk("bp_in_ready_low", 64'(stall_cnt > 0), 64'd1);
        chk("bp_count", 64'(pops - p0), 64'd4096);

        // Mid-operation reset with two transactions in flight.
        out_ready = 1'b0;
        send(54'd11, 54'd3, 54'd97, 54'd8);
        send(54'd20, 54'd30, 54'd97, 54'd87);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        rstn = 1'b0;
        @(negedge clk);
        chk("rstlow_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_out", 64'(out), 64'd0);
        exp_q.delete();
        rstn = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        send(54'd3, 54'd11, 54'd97, 54'd89);
        chk("flush_lat1_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("flush_lat2_valid", 64'(out_valid), 64'd1);
        chk("flush_lat2_out", 64'(out), 64'd89);
        drain();
        repeat (5) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mod_sub_unit.md
Name: mod_sub_unit

Overview:
Pipelined modular subtractor: computes out = (a - b) mod q for operands already reduced into [0, q). It is the subtract leaf used by the NTT butterfly and the ring-arithmetic datapaths of the FHE accelerator. It is a two-stage registered pipeline with a valid/ready handshake on both sides.

Parameters:
BIT_WIDTH, 54, width of operands, modulus and result (matches the global `BIT_WIDTH`; default modulus class is 54-bit, e.g. q = 0x3F_FFFF_FFFE_D001).

Ports:
clk  input  1  clock; all state updates on rising edge
rstn  input  1  synchronous active-low reset
in_valid  input  1  a/b/q valid this cycle
in_ready  output  1  unit can accept an operand set this cycle
a  input  BIT_WIDTH  minuend, 0 <= a < q
b  input  BIT_WIDTH  subtrahend, 0 <= b < q
q  input  BIT_WIDTH  modulus, 2 <= q < 2^BIT_WIDTH, sampled per transaction
out_valid  output  1  out holds a valid result
out_ready  input  1  downstream accepts result this cycle
out  output  BIT_WIDTH  (a - b) mod q

Behaviour:
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready.
- Stage 1 register, loaded on input transfer:
  - diff = {1'b0,a} - {1'b0,b}, computed at BIT_WIDTH+1 bits; the MSB is the borrow.
  - Capture the low BIT_WIDTH bits of diff, the borrow, and q.
- Stage 2 register (the output):
  - out = borrow ? (diff[BIT_WIDTH-1:0] + q) truncated to BIT_WIDTH : diff[BIT_WIDTH-1:0].
  - out_valid is set with it.
- Latency: exactly 2 cycles from input transfer to out_valid with no backpressure. Throughput: 1 result per cycle.
- Each stage holds its contents while it is valid and the next stage cannot accept. Stage 2 accepts when it is empty or out_ready=1. Stage 1 advances when stage 2 accepts.
- in_ready = rstn && (!s1_valid || s1 advancing). It is combinational and may depend on out_ready. No combinational path from in_valid to out_valid.
- Results emerge in input order. No drops or duplicates under any out_ready pattern.
- out and out_valid are registered. out is stable while out_valid=1 and out_ready=0.
- Reset (rstn low at a rising edge):
  - Both stage valids clear, out_valid=0, out=0, in_ready=0 while rstn=0.
  - Applies mid-operation: in-flight transactions are discarded and never emerge.
  - in_ready returns to 1 the first cycle rstn=1.
- Boundaries:
  - a == b gives 0.
  - a = 0, b = 1 gives q-1.
  - a = q-1, b = 0 gives q-1.
  - The borrow path adds q exactly once.
- Out-of-range inputs (a >= q or b >= q): no error flag. The result is the same formula truncated to BIT_WIDTH; correctness is not guaranteed.
- Simultaneous input transfer and output transfer in the same cycle are legal and both take effect.

Test Plan:
- Reset then q=0x3FFFFFFFFED001, a=0, b=0, out_ready=1 -> out_valid 2 cycles later, out=0.
- a=q-1, b=q-1 -> 0. a=2, b=q-1 -> 3. a=0, b=1 -> 0x3FFFFFFFFED000.
- 4096 back-to-back random a,b (masked to BIT_WIDTH, reduced mod q), out_ready=1 -> each out == (a-b+q)%q, in order, one per cycle after 2-cycle fill.
- Random out_ready toggling with continuous in_valid -> in_ready deasserts when the pipe is full; all 4096 results correct and in order; out is stable while stalled.
- Assert rstn=0 for one cycle with two transactions in flight -> out_valid=0 and out=0 next cycle; the flushed results never appear; the next transaction has normal 2-cycle latency.
- Change q per transaction (q=97: a=5, b=10 -> 92; q=0x3FFFFFFFFED001: a=10, b=5 -> 5) -> each result uses its own q.
